// File: rtl/mips_pkg.sv
// Constants and types shared by the P5 MIPS fetch stage and the CP0/exception logic.
package mips_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    // Response stage: the fetch issued last cycle, now presented to F/D.
    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        squash;
        logic        bad;
    } resp_t;

endpackage

// File: rtl/im_addr_chk.sv
// Range/alignment check and word-address translation for a memory window at BASE.
module im_addr_chk #(
    parameter logic [31:0] BASE   = mips_pkg::IM_BASE,
    parameter int unsigned WORDS  = mips_pkg::IM_WORDS,
    parameter int unsigned ADDR_W = $clog2(WORDS)
) (
    input  logic [31:0]       addr,
    output logic              ok,
    output logic [ADDR_W-1:0] word
);

    // Bounds are 33 bits wide so a window ending at 4 GiB does not wrap to zero.
    localparam logic [32:0] LO = {1'b0, BASE};
    localparam logic [32:0] HI = LO + 33'(WORDS) * 33'd4;

    assign ok   = (addr[1:0] == 2'b00) && ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    assign word = ADDR_W'((addr - BASE) >> 2);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer for a 1-cycle-latency instruction memory: PC, stall hold, delay-slot redirects, AdEL.
module if_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
    parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
    parameter int unsigned IM_WORDS = mips_pkg::IM_WORDS,
    parameter int unsigned ADDR_W   = $clog2(IM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              im_en_o,
    output logic [ADDR_W-1:0] im_addr_o,
    input  logic [31:0]       im_rdata_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              instr_valid_o,
    output logic              exc_adel_o
);

    logic [31:0]     pc_q;
    logic            pc_ok;
    mips_pkg::resp_t resp;
    logic            hold_valid;
    logic [31:0]     hold_instr;

    im_addr_chk #(
        .BASE   (IM_BASE),
        .WORDS  (IM_WORDS),
        .ADDR_W (ADDR_W)
    ) u_chk (
        .addr (pc_q),
        .ok   (pc_ok),
        .word (im_addr_o)
    );

    // Gating with reset keeps the IM idle while reset is held, independent of pc_q.
    assign im_en_o = reset && !stall_i && pc_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= PC_RESET;
            resp       <= '0;
            hold_valid <= 1'b0;
            hold_instr <= mips_pkg::NOP;
        end else if (stall_i) begin
            // IM output is only trustworthy on the first stalled cycle; keep a copy.
            if (!hold_valid) begin
                hold_instr <= im_rdata_i;
                hold_valid <= 1'b1;
            end
        end else begin
            resp.pc     <= pc_q;
            resp.valid  <= 1'b1;
            resp.bad    <= !pc_ok;
            resp.squash <= redirect_i;
            pc_q        <= redirect_i ? redirect_pc_i : pc_q + 32'd4;
            hold_valid  <= 1'b0;
        end
    end

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        instr_o       = mips_pkg::NOP;
        pc_o          = '0;
        instr_valid_o = 1'b0;
        exc_adel_o    = 1'b0;
        if (resp.valid) begin
            pc_o          = resp.pc;
            instr_valid_o = !resp.squash;
            exc_adel_o    = !resp.squash && resp.bad;
            if (!resp.squash && !resp.bad) begin
                instr_o = hold_valid ? hold_instr : im_rdata_i;
            end
        end
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage sequencer for a synchronous-read (1-cycle latency) instruction memory in the P5 pipelined MIPS.
- Owns the fetch PC and issues one IM read per cycle.
- Honours hazard-unit stalls with an internal hold buffer, applies D-stage branch/jump redirects with MIPS delay-slot semantics, and flags out-of-range or misaligned fetch addresses (AdEL) instead of reading.
- Output feeds the F/D pipeline register.

Parameters:
- PC_RESET, 32'h00003000, fetch PC after reset.
- IM_BASE, 32'h00003000, byte address of IM word 0.
- IM_WORDS, 4096, IM depth in words.
- ADDR_W, 12, IM word-address width (log2 IM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard unit: freeze fetch and hold the presented instruction.
- redirect_i  in  1  D-stage branch taken / jump; ignored while stall_i=1.
- redirect_pc_i  in  32  target byte address.
- im_en_o  out  1  IM read enable.
- im_addr_o  out  ADDR_W  IM word address.
- im_rdata_i  in  32  IM data; valid the cycle after im_en_o=1.
- instr_o  out  32  fetched instruction to F/D.
- pc_o  out  32  byte address of instr_o.
- instr_valid_o  out  1  instr_o/pc_o are a real, unsquashed instruction.
- exc_adel_o  out  1  pc_o is out of IM range or misaligned; instr_o forced to 0.

Behaviour:
- State: pc_q (address issued this cycle); response stage pc_r, valid_r, squash_r, bad_r; hold_valid, hold_instr.
- Reset while reset=0, any cycle, including mid-stall or mid-redirect:
  - pc_q=PC_RESET; valid_r, squash_r, bad_r, hold_valid all 0; hold_instr=0.
  - Outputs: instr_o=0, pc_o=0, instr_valid_o=0, exc_adel_o=0, im_en_o=0.
- ok(pc): pc[1:0]==0 and IM_BASE <= pc < IM_BASE+4*IM_WORDS. Compare unsigned in 33 bits so the upper bound does not wrap.
- Address: im_addr_o = (pc_q - IM_BASE)[ADDR_W+1:2].
- Enable: im_en_o = !stall_i && ok(pc_q). Driven combinationally, low during reset.
- Latency: PC issued in cycle t is presented on instr_o/pc_o in cycle t+1.
- Non-stall cycle (stall_i=0):
  - pc_r<=pc_q; valid_r<=1; bad_r<=!ok(pc_q).
  - pc_q<=redirect_i ? redirect_pc_i : pc_q+4, with 32-bit wrap.
  - squash_r<=redirect_i.
- Delay slot and squash:
  - On a redirect cycle, the instruction currently presented is the delay slot and stays valid.
  - The sequential address issued in that same cycle returns next cycle with squash_r=1. It shows instr_valid_o=0, instr_o=0, exc_adel_o=0.
- Stall cycle (stall_i=1): pc_q, pc_r, valid_r, squash_r and bad_r hold. No IM read. redirect_i is ignored.
  - First stall cycle with hold_valid=0: hold_instr<=im_rdata_i; hold_valid<=1.
  - hold_valid clears on the first non-stall cycle.
- Output mux:
  - instr_o = (!valid_r || squash_r || bad_r) ? 0 : (hold_valid ? hold_instr : im_rdata_i).
  - pc_o = valid_r ? pc_r : 0.
  - instr_valid_o = valid_r && !squash_r.
  - exc_adel_o = instr_valid_o && bad_r.
- Boundaries:
  - Last IM word (IM_BASE+4*IM_WORDS-4) is fetched normally; the next sequential PC raises AdEL.
  - Fetching continues past a bad PC, with AdEL on every bad one, until a redirect.
  - Redirect to a misaligned target: AdEL two cycles later; no IM read is issued for it.
  - Stall asserted the first cycle after reset release (valid_r=0): hold captures garbage, but instr_valid_o=0 masks it.
  - Stall and redirect in the same cycle: the stall wins.

Decomposition:
- Shared package mips_pkg holds: PC_RESET, IM_BASE, IM_WORDS, NOP (32'h0) and the AdEL exception code (5'd4). These are shared with the CP0/exception logic.
- One natural sub-module, im_addr_chk: combinational ok()/word-address computation. It is reused by the DM controller with different bounds.

Test Plan:
- Reset release, no stall/redirect:
  - im_addr_o = 0, 1, 2.
  - instr_o/pc_o = mem[0]/0x3000, mem[1]/0x3004 in the cycles after; instr_valid_o=1.
- Redirect at PC 0x3008 (branch in D, presented 0x300C) to 0x3040:
  - 0x300C stays valid (delay slot).
  - Next cycle shows pc_o=0x3010 with instr_valid_o=0.
  - Then 0x3040 is presented with instr_valid_o=1.
- stall_i held 3 cycles while 0x3004 is presented:
  - instr_o=mem[1], pc_o=0x3004 stable; im_en_o=0.
  - After release, 0x3008 follows with no gap and no duplicate.
- Redirect to 0x3002 → exc_adel_o=1, instr_o=0, pc_o=0x3002; redirect to 0x7000 → exc_adel_o=1, no im_en_o for it.
- Sequential run from 0x6FF8 → 0x6FF8 and 0x6FFC valid; 0x7000 flagged AdEL.
- Reset pulse mid-stall and mid-redirect:
  - All outputs 0 immediately (asynchronous).
  - Fetch restarts at 0x3000 with hold_valid cleared.
